// File: rtl/artemis_pll_sequencer.sv
// rtl/artemis_pll_sequencer.sv - DDR3 clock PLL reset/lock sequencer with timeout retry and sticky fault
module artemis_pll_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ddr3_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    READY      = 3'd3,
    FAULT      = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 lock_meta;
  logic                 locked_s;

  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_HOLD;
      cnt         <= '0;
      lock_meta   <= 1'b0;
      locked_s    <= 1'b0;
      pll_rst     <= 1'b1;
      ddr3_rst    <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 4'd0;
    end else begin
      // pll_locked comes from the PLL domain; two flops before any decision uses it
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
      lock_lost <= 1'b0;

      if (restart) begin
        state       <= RESET_HOLD;
        cnt         <= '0;
        retry_count <= 4'd0;
        fault       <= 1'b0;
        pll_rst     <= 1'b1;
        ddr3_rst    <= 1'b1;
        ready       <= 1'b0;
      end else begin
        case (state)
          RESET_HOLD: begin
            if (cnt == RESET_LAST) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          WAIT_LOCK: begin
            if (locked_s) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt     <= '0;
              pll_rst <= 1'b1;
              if (retry_count == RETRY_LIMIT) begin
                state <= FAULT;
                fault <= 1'b1;
              end else begin
                state       <= RESET_HOLD;
                retry_count <= retry_count + 4'd1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          STABLE: begin
            // a dropout here is treated as a glitch: back to waiting, no retry charged
            if (!locked_s) begin
              state <= WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state       <= READY;
              cnt         <= '0;
              ready       <= 1'b1;
              ddr3_rst    <= 1'b0;
              retry_count <= 4'd0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          READY: begin
            if (!locked_s) begin
              state     <= RESET_HOLD;
              cnt       <= '0;
              lock_lost <= 1'b1;
              ready     <= 1'b0;
              ddr3_rst  <= 1'b1;
              pll_rst   <= 1'b1;
            end
          end

          FAULT: begin
            pll_rst  <= 1'b1;
            ddr3_rst <= 1'b1;
            ready    <= 1'b0;
            fault    <= 1'b1;
          end

          default: begin
            state    <= RESET_HOLD;
            cnt      <= '0;
            pll_rst  <= 1'b1;
            ddr3_rst <= 1'b1;
            ready    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
